// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the FIFO-draining UART transmitter.
//   uart_state_e     : transmitter FSM states (StParity is used only when
//                      UART_TX_PARITY_EN is defined)
//   CLKS_PER_BIT_DEF : default clk cycles per serial bit
//   DATA_W_DEF       : default character width, matches the byte FIFO
//   IDLE_LEVEL       : level of the serial line when no frame is in flight
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StLatch,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  localparam int unsigned CLKS_PER_BIT_DEF = 16;
  localparam int unsigned DATA_W_DEF       = 8;
  localparam logic        IDLE_LEVEL       = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 and wraps; clr forces it back to 0.
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   clr     : restart the bit period (asserted on every FSM state change)
//   bit_end : high on the last cycle of a bit period (count == CLKS_PER_BIT-1)
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);

  localparam int unsigned   CntW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign bit_end = (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clr || bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: pops bytes from the 8-bit synchronous FIFO whenever it is
// non-empty and the transmitter is idle, and sends each as a UART frame
// (start, DATA_W data bits LSB first, stop). Back-to-back bytes are separated
// by exactly two idle-high cycles (pop request + data latch).
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between
// the data bits and the stop bit.
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset; abandons any frame in flight
//   fifo_empty : FIFO empty flag, sampled only in idle and at the end of stop
//   fifo_data  : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en : one-cycle pop request, exactly one per frame
//   tx         : serial line, idle high
//   busy       : high whenever the transmitter is not idle
//   tx_done    : one-cycle pulse on the last cycle of the stop bit
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int unsigned     IdxW    = $clog2(DATA_W);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_W - 1);

  uart_state_e       state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              tx_q, tx_d;
  logic              bit_end;
  logic              baud_clr;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  // Idle holds the counter at zero so the first bit of a frame is full length.
  assign baud_clr = (state_d != state_q) || (state_q == StIdle);

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (baud_clr),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      StIdle: begin
        if (!fifo_empty) state_d = StReq;
      end
      StReq: begin
        state_d = StLatch;
      end
      StLatch: begin
        shift_d  = fifo_data;
`ifdef UART_TX_PARITY_EN
        parity_d = ^fifo_data;
`endif
        state_d  = StStart;
      end
      StStart: begin
        if (bit_end) state_d = StData;
      end
      StData: begin
        if (bit_end) begin
          if (idx_q == IdxLast) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            idx_d   = idx_q + IdxW'(1);
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) state_d = StStop;
      end
`endif
      StStop: begin
        // Chain straight into the next pop when more data is waiting.
        if (bit_end) state_d = fifo_empty ? StIdle : StReq;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // tx is registered from the next state so the pin never glitches.
  always_comb begin
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: tx_d = parity_d;
`endif
      default:  tx_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      idx_q    <= '0;
      tx_q     <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign fifo_rd_en = (state_q == StReq);
  assign busy       = (state_q != StIdle);
  assign tx_done    = (state_q == StStop) && bit_end;
  assign tx         = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb_uart_tx_fifo_drain: self-checking bench for uart_tx_fifo_drain with
// CLKS_PER_BIT=4. A queue-based FIFO model feeds the DUT; each frame is checked
// cycle by cycle against the expected line level derived from the byte value.
// Honours UART_TX_PARITY_EN for the expected frame length and parity bit.
module tb_uart_tx_fifo_drain;

  localparam int unsigned Cpb = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned Slots = 11;
`else
  localparam int unsigned Slots = 10;
`endif
  localparam int unsigned FrameLen = Slots * Cpb;

  logic       clk        = 1'b0;
  logic       rst        = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data  = '0;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;
  logic       tx_done;

  int checks    = 0;
  int failures  = 0;
  int pops      = 0;
  int underruns = 0;
  int exp_pops  = 0;

  logic [7:0] fifo_q[$];

  uart_tx_fifo_drain #(
    .CLKS_PER_BIT (Cpb),
    .DATA_W       (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  // FIFO model: registered read data and registered empty flag.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fifo_q.size() > 0) begin
        fifo_data <= fifo_q.pop_front();
        pops      <= pops + 1;
      end else begin
        underruns <= underruns + 1;
      end
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected line level c cycles into a frame (c=0 is the first start-bit cycle).
  function automatic logic exp_level(input logic [7:0] b, input int unsigned c);
    int unsigned slot;
    logic [7:0]  sh;
    slot = c / Cpb;
    if (slot == 0) return 1'b0;
    if (slot <= 8) begin
      sh = b >> (slot - 1);
      return sh[0];
    end
`ifdef UART_TX_PARITY_EN
    if (slot == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_pops++;
  endtask

  task automatic expect_idle(input string tag);
    check_eq({tag, "_tx"}, 32'(tx), 32'd1);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
    check_eq({tag, "_done"}, 32'(tx_done), 32'd0);
  endtask

  task automatic wait_req(input int unsigned limit);
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (fifo_rd_en !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_seen", 32'(fifo_rd_en), 32'd1);
  endtask

  // Called at the negedge where the pop request is visible. Checks the request
  // cycle, the latch cycle and every frame cycle. Optionally pushes mid_b into
  // the FIFO halfway through the frame.
  task automatic check_frame(input logic [7:0] b, input bit push_mid, input logic [7:0] mid_b);
    check_eq("req_rd_en", 32'(fifo_rd_en), 32'd1);
    check_eq("req_tx", 32'(tx), 32'd1);
    check_eq("req_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check_eq("latch_rd_en", 32'(fifo_rd_en), 32'd0);
    check_eq("latch_tx", 32'(tx), 32'd1);
    check_eq("latch_busy", 32'(busy), 32'd1);
    for (int unsigned c = 0; c < FrameLen; c++) begin
      @(negedge clk);
      if (push_mid && c == FrameLen / 2) push(mid_b);
      check_eq($sformatf("frame_tx b=%0h c=%0d", b, c), 32'(tx), 32'(exp_level(b, c)));
      check_eq($sformatf("frame_done c=%0d", c), 32'(tx_done), 32'(c == FrameLen - 1));
      check_eq("frame_busy", 32'(busy), 32'd1);
      check_eq("frame_rd_en", 32'(fifo_rd_en), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] burst_q[$];
    logic [7:0] b;
    logic [7:0] mid_b;
    bit         mid;

    // Reset held with data waiting: line stays idle, no pop.
    push(8'h5A);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      expect_idle("reset");
    end
    rst = 1'b0;
    @(negedge clk);
    check_frame(8'h5A, 1'b0, 8'h00);
    @(negedge clk);
    expect_idle("after_5a");
    check_eq("pops_5a", 32'(pops), 32'(exp_pops));

    // Single byte.
    push(8'hA5);
    wait_req(10);
    check_frame(8'hA5, 1'b0, 8'h00);
    @(negedge clk);
    expect_idle("after_a5");
    check_eq("pops_a5", 32'(pops), 32'(exp_pops));

    // Back-to-back pair: next pop immediately after the stop bit.
    push(8'h00);
    push(8'hFF);
    wait_req(10);
    check_frame(8'h00, 1'b0, 8'h00);
    @(negedge clk);
    check_frame(8'hFF, 1'b0, 8'h00);
    @(negedge clk);
    expect_idle("after_pair");
    check_eq("pops_pair", 32'(pops), 32'(exp_pops));

    // Long empty stretch.
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      expect_idle("empty");
    end
    check_eq("pops_empty", 32'(pops), 32'(exp_pops));

    // Reset during data bit 3 of 8'h3C; the popped byte is lost.
    push(8'h3C);
    wait_req(10);
    @(negedge clk);
    for (int unsigned c = 0; c < 4 * Cpb + 2; c++) begin
      @(negedge clk);
      check_eq("pre_abort_tx", 32'(tx), 32'(exp_level(8'h3C, c)));
    end
    rst = 1'b1;
    push(8'hC3);
    @(negedge clk);
    expect_idle("abort");
    @(negedge clk);
    expect_idle("abort_hold");
    rst = 1'b0;
    @(negedge clk);
    check_frame(8'hC3, 1'b0, 8'h00);
    @(negedge clk);
    expect_idle("after_abort");
    check_eq("pops_abort", 32'(pops), 32'(exp_pops));

    // Byte with odd bit count (parity bit 1 when enabled).
    push(8'h07);
    wait_req(10);
    check_frame(8'h07, 1'b0, 8'h00);
    @(negedge clk);
    expect_idle("after_07");

    // Random bursts, occasionally refilling the FIFO mid-frame.
    for (int k = 0; k < 8; k++) begin
      burst_q.delete();
      for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
        b = 8'($urandom);
        burst_q.push_back(b);
        push(b);
      end
      wait_req(10);
      while (burst_q.size() > 0) begin
        b     = burst_q.pop_front();
        mid   = (burst_q.size() == 0) && ($urandom_range(0, 2) == 0);
        mid_b = 8'($urandom);
        if (mid) burst_q.push_back(mid_b);
        check_frame(b, mid, mid_b);
        @(negedge clk);
      end
      expect_idle("after_burst");
      repeat ($urandom_range(0, 5)) begin
        @(negedge clk);
        expect_idle("gap");
      end
    end

    check_eq("pops_total", 32'(pops), 32'(exp_pops));
    check_eq("underruns", 32'(underruns), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
